// File: rtl/input_map_pkg.sv
// Shared constants for the memory-mapped button input block: register offsets and button count.
package input_map_pkg;

  localparam int unsigned NumButtons = 8;

  localparam logic [31:0] AddrState   = 32'd0;
  localparam logic [31:0] AddrPending = 32'd4;
  localparam logic [31:0] AddrRaw     = 32'd8;
  localparam logic [31:0] AddrMask    = 32'd12;

endpackage

// File: rtl/input_debounce.sv
// One button lane: two-flop synchronizer followed by a hold-time debouncer with a rise pulse.
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic sync,
  output logic out,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flip;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    flip  = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntLast) begin
        flip  = 1'b1;
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync = sync2_q;
  assign out  = deb_q;
  // Combinational so the owner can latch PENDING on the same edge the debounced bit rises.
  assign rise = flip & ~deb_q & ~rst;

endmodule

// File: rtl/input_map.sv
// Memory-mapped debounced button block: STATE/PENDING/RAW/MASK registers and a level interrupt.
module input_map
  import input_map_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_address,
  input  logic [31:0] input_in,
  input  logic [1:0]  input_size,
  input  logic        input_write_enable,
  output logic [31:0] input_out,
  input  logic [7:0]  buttons,
  output logic        irq
);

  logic [NumButtons-1:0] raw_vec, state_vec, rise_vec;
  logic [NumButtons-1:0] pending_q, pending_d;
  logic [NumButtons-1:0] mask_q, mask_d;
  logic [NumButtons-1:0] rdata;
  logic [31:0]           out_q;
  logic                  wr_pending, wr_mask;

  // Access size is irrelevant: every access is a full word.
  logic unused_bits;
  assign unused_bits = ^{input_size, input_in[31:NumButtons]};

  for (genvar i = 0; i < NumButtons; i++) begin : g_lane
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk (clk),
      .rst (rst),
      .in  (buttons[i]),
      .sync(raw_vec[i]),
      .out (state_vec[i]),
      .rise(rise_vec[i])
    );
  end

  assign wr_pending = input_write_enable && (input_address == AddrPending);
  assign wr_mask    = input_write_enable && (input_address == AddrMask);

  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    if (wr_pending) pending_d = pending_d & ~input_in[NumButtons-1:0];
    // A rise on the same edge as a clear wins.
    pending_d = pending_d | rise_vec;
    if (wr_mask) mask_d = input_in[NumButtons-1:0];
  end

  always_comb begin
    rdata = '0;
    unique case (input_address)
      AddrState:   rdata = state_vec;
      AddrPending: rdata = pending_q;
      AddrRaw:     rdata = raw_vec;
      AddrMask:    rdata = mask_q;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
      out_q     <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      out_q     <= {{(32 - NumButtons){1'b0}}, rdata};
    end
  end

  assign input_out = out_q;
  assign irq       = |(pending_q & mask_q);

endmodule

// File: tb/tb_input_map.sv
// Directed bench for input_map with DEBOUNCE_CYCLES=4; expected values computed by hand.
module tb_input_map;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_address;
  logic [31:0] input_in;
  logic [1:0]  input_size;
  logic        input_write_enable;
  logic [31:0] input_out;
  logic [7:0]  buttons;
  logic        irq;

  int pass_count  = 0;
  int check_count = 0;

  input_map #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .input_address     (input_address),
    .input_in          (input_in),
    .input_size        (input_size),
    .input_write_enable(input_write_enable),
    .input_out         (input_out),
    .buttons           (buttons),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reads take one edge: the sampled value appears on input_out just after it.
  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    input_address = addr;
    tick();
    check(tag, input_out, exp);
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    input_address      = addr;
    input_in           = data;
    input_write_enable = 1'b1;
    tick();
    input_write_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; input_address = '0; input_in = '0; input_size = 2'd2;
    input_write_enable = 1'b0; buttons = 8'h00;
    tick(3);
    check("reset_out", input_out, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    read_chk("rst_state", 32'd0, 32'h0);
    read_chk("rst_pending", 32'd4, 32'h0);
    read_chk("rst_raw", 32'd8, 32'h0);
    read_chk("rst_mask", 32'd12, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // 3-cycle glitch on bit 0 must be rejected.
    input_address = 32'd0;
    buttons = 8'h01;
    tick(3);
    buttons = 8'h00;
    tick(8);
    read_chk("glitch_state", 32'd0, 32'h0);
    read_chk("glitch_pending", 32'd4, 32'h0);

    // Held change: RAW after 2 edges, STATE 4 edges later.
    input_address = 32'd8;
    buttons = 8'h05;
    tick(2);
    check("raw_early", input_out, 32'h0);
    tick();
    check("raw_seen", input_out, 32'h05);
    input_address = 32'd0;
    tick(3);
    check("state_early", input_out, 32'h0);
    tick();
    check("state_seen", input_out, 32'h05);
    read_chk("pending_set", 32'd4, 32'h05);

    // Mask and interrupt; read concurrent with write returns the old value.
    write(32'd12, 32'h01);
    check("mask_rd_prewrite", input_out, 32'h0);
    check("irq_on", {31'b0, irq}, 32'h1);
    read_chk("mask_rd", 32'd12, 32'h01);
    write(32'd4, 32'h01);
    check("irq_off", {31'b0, irq}, 32'h0);
    read_chk("pending_w1c", 32'd4, 32'h04);

    // Bit 2 falls: PENDING keeps it; clear it, then re-rise against a clear.
    buttons = 8'h01;
    tick(8);
    read_chk("fall_state", 32'd0, 32'h01);
    read_chk("fall_pending", 32'd4, 32'h04);
    write(32'd4, 32'h04);
    read_chk("pending_clr2", 32'd4, 32'h0);
    buttons = 8'h05;
    tick(5);
    write(32'd4, 32'h04);
    read_chk("set_beats_clear", 32'd4, 32'h04);
    read_chk("state_rerise", 32'd0, 32'h05);

    // Unmapped addresses and writes to read-only registers.
    read_chk("addr16", 32'd16, 32'h0);
    read_chk("addr1", 32'd1, 32'h0);
    write(32'd0, 32'hFF);
    read_chk("state_ro", 32'd0, 32'h05);
    write(32'd8, 32'hFF);
    read_chk("raw_ro", 32'd8, 32'h05);

    // Reset mid-debounce on bit 7, then release with buttons still held.
    input_address = 32'd0;
    buttons = 8'h85;
    tick(4);
    rst = 1'b1;
    tick();
    check("midrst_out", input_out, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    tick(6);
    check("post_rst_early", input_out, 32'h0);
    tick();
    check("post_rst_state", input_out, 32'h85);
    read_chk("post_rst_pending", 32'd4, 32'h85);
    read_chk("post_rst_mask", 32'd12, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/input_map.md
INPUT_MAP -- requirements
Module: input_map

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: cycles a synchronized button value must hold before it is accepted; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port input_address  input  32  bus byte address.
REQ-005 SHALL have port input_in  input  32  bus write data.
REQ-006 SHALL have port input_size  input  2  access size; ignored, every access is treated as a full word.
REQ-007 SHALL have port input_write_enable  input  1  write strobe.
REQ-008 SHALL have port input_out  output  32  registered read data.
REQ-009 SHALL have port buttons  input  8  asynchronous board buttons/switches.
REQ-010 SHALL have port irq  output  1  level interrupt request.

Function
REQ-011 SHALL decode the full 32-bit address: 0 = STATE (RO), 4 = PENDING (W1C), 8 = RAW (RO), 12 = MASK (RW); all other addresses read 0 and ignore writes.
REQ-012 SHALL pass each buttons bit through a two-flop synchronizer; RAW returns the second-flop value.
REQ-013 SHALL keep, per bit, a debounced value and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-014 SHALL clear the counter in any cycle where the synchronized bit equals the debounced bit.
REQ-015 SHALL increment the counter in any cycle of mismatch; when the counter equals DEBOUNCE_CYCLES-1 and a mismatch persists, SHALL flip the debounced bit and clear the counter in that same edge.
REQ-016 SHALL therefore update the debounced bit exactly DEBOUNCE_CYCLES edges after the synchronized bit first differs, provided no glitch back intervenes; any single-cycle return to agreement restarts the count.
REQ-017 SHALL present the debounced vector on STATE bits [7:0].
REQ-018 SHALL set PENDING[i] on the edge where debounced bit i goes 0->1; falling transitions do not set it.
REQ-019 SHALL clear PENDING[i] on a write to address 4 with input_in[i]=1; bits written 0 are unchanged.
REQ-020 SHALL give set priority over clear when both occur on the same edge for the same bit.
REQ-021 SHALL load MASK[7:0] from input_in[7:0] on a write to address 12.
REQ-022 SHALL drive irq = OR of (PENDING & MASK), combinational from registers with no added latency.
REQ-023 SHALL register input_out every cycle as {24'b0, selected register} for the current input_address; one-cycle read latency, no read strobe, reads have no side effects.
REQ-024 SHALL, on a read concurrent with a write to the same register, return the pre-write value.

Reset
REQ-025 SHALL, while rst is high, zero the synchronizer flops, debounced vector, all counters, PENDING, MASK, input_out; irq is 0.
REQ-026 SHALL abort any in-progress debounce count on reset; counting restarts from 0 afterwards.
REQ-027 SHALL treat a button held high through reset release as a 0->1 change: the debounced bit rises and sets PENDING after 2+DEBOUNCE_CYCLES cycles.

Structure
REQ-028 SHALL place address constants (STATE, PENDING, RAW, MASK) and the button count (8) in package input_map_pkg.
REQ-029 SHALL implement one bit of synchronizer plus debounce as sub-module input_debounce (ports clk, rst, in, out, rise), instantiated once per button.
REQ-030 SHALL keep register decode, PENDING, MASK, and the read mux in input_map.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset with buttons=0x00, read addr 0/4/8/12 -> input_out 0 for each, irq 0.
REQ-032 buttons 0x00->0x05 held -> RAW=0x05 2 cycles later, STATE=0x05 4 cycles after that, PENDING=0x05.
REQ-033 bit 0 pulses high for 3 cycles then low -> STATE stays 0x00, PENDING stays 0x00.
REQ-034 MASK<-0x01, PENDING=0x05 -> irq 1; write 0x01 to addr 4 -> PENDING 0x04, irq 0; write 0x04 in the same edge bit 2 re-rises -> PENDING bit 2 stays 1.
REQ-035 Read addr 16 and addr 1 -> input_out 0; write 0xFF to addr 0 -> STATE unchanged.
REQ-036 rst asserted after 2 of 4 debounce cycles -> all outputs 0; after release with button still high, STATE bit rises 6 cycles later.
